// File: rtl/relay_station_mc.sv
// relay_station_mc: multi-lane first-word fall-through relay station.
// Each lane carries a FIFO stream across LEVEL forward register stages,
// with a matching LEVEL-deep full_n return path. The lane ends in a small
// FIFO whose almost-full threshold leaves room for every word still in
// flight. Per lane, the block also reports occupancy and a sticky overflow
// flag. LEVEL == 0 collapses the whole block to plain wires.
module relay_station_mc #(
    parameter int DATA_WIDTH = 32,
    parameter int CHANNELS   = 1,
    parameter int LEVEL      = 2,
    parameter int DEPTH      = 2,
    localparam int GRACE      = 2 * LEVEL,
    localparam int REAL_DEPTH = DEPTH + GRACE + 4,
    localparam int CNT_W      = $clog2(REAL_DEPTH + 1)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           if_write_ce,
    input  logic [CHANNELS-1:0]            if_write,
    input  logic [CHANNELS*DATA_WIDTH-1:0] if_din,
    output logic [CHANNELS-1:0]            if_full_n,
    input  logic                           if_read_ce,
    input  logic [CHANNELS-1:0]            if_read,
    output logic [CHANNELS-1:0]            if_empty_n,
    output logic [CHANNELS*DATA_WIDTH-1:0] if_dout,
    output logic [CHANNELS*CNT_W-1:0]      occupancy,
    output logic [CHANNELS-1:0]            overflow,
    input  logic                           overflow_clear
);

    if (LEVEL == 0) begin : g_wire
        assign if_full_n  = if_read;
        assign if_empty_n = if_write;
        assign if_dout    = if_din;
        assign occupancy  = '0;
        assign overflow   = '0;
    end else begin : g_pipe
        localparam int PTR_W = $clog2(REAL_DEPTH);
        localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(REAL_DEPTH);
        localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(REAL_DEPTH - 1 - GRACE);
        localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(REAL_DEPTH - 1);

        for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
            logic                  wr;
            logic                  tail_full_n;
            logic                  push;
            logic                  pop;
            logic                  do_push;
            logic [LEVEL-1:0]      fwd_valid;
            logic [DATA_WIDTH-1:0] fwd_data [LEVEL];
            logic [LEVEL-1:0]      bwd_full_n;
            logic [DATA_WIDTH-1:0] mem [REAL_DEPTH];
            logic [PTR_W-1:0]      rd_ptr;
            logic [PTR_W-1:0]      wr_ptr;
            logic [CNT_W-1:0]      count;
            logic                  ovf;

            assign wr          = if_write[k] & if_write_ce & bwd_full_n[LEVEL-1];
            assign push        = fwd_valid[LEVEL-1];
            assign pop         = if_read[k] & if_read_ce & (count != '0);
            // A push into a full FIFO only lands if the head leaves in the same cycle.
            assign do_push     = push & ((count != FULL_CNT) | pop);
            assign tail_full_n = ~(count >= AF_CNT);

            // Shift the forward valid bits and backward full_n bits one stage per cycle.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    fwd_valid  <= '0;
                    bwd_full_n <= '0;
                end else begin
                    fwd_valid[0]  <= wr;
                    bwd_full_n[0] <= tail_full_n;
                    for (int i = 1; i < LEVEL; i++) begin
                        fwd_valid[i]  <= fwd_valid[i-1];
                        bwd_full_n[i] <= bwd_full_n[i-1];
                    end
                end
            end

            // Payload pipeline and FIFO storage; these are not reset, because the valid bits qualify them.
            always_ff @(posedge clk) begin
                fwd_data[0] <= if_din[k*DATA_WIDTH +: DATA_WIDTH];
                for (int i = 1; i < LEVEL; i++) begin
                    fwd_data[i] <= fwd_data[i-1];
                end
                if (do_push) begin
                    mem[wr_ptr] <= fwd_data[LEVEL-1];
                end
            end

            // Pointers, count and the sticky overflow flag; a new overflow beats a clear.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    rd_ptr <= '0;
                    wr_ptr <= '0;
                    count  <= '0;
                    ovf    <= 1'b0;
                end else begin
                    if (do_push) begin
                        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
                    end
                    if (pop) begin
                        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
                    end
                    if (do_push && !pop) begin
                        count <= count + 1'b1;
                    end else if (pop && !do_push) begin
                        count <= count - 1'b1;
                    end
                    if (push && !do_push) begin
                        ovf <= 1'b1;
                    end else if (overflow_clear) begin
                        ovf <= 1'b0;
                    end
                end
            end

            assign if_full_n[k]                           = bwd_full_n[LEVEL-1];
            assign if_empty_n[k]                          = (count != '0);
            assign if_dout[k*DATA_WIDTH +: DATA_WIDTH]    = mem[rd_ptr];
            assign occupancy[k*CNT_W +: CNT_W]            = count;
            assign overflow[k]                            = ovf;
        end
    end

endmodule

// File: tb/tb_relay_station_mc.sv
// Testbench for relay_station_mc. It uses two lanes, LEVEL=2 and DEPTH=2.
// Stimulus is random and targeted. A queue-based reference model of lane
// behaviour produces the expected values.
module tb_relay_station_mc;

    localparam int DW  = 32;
    localparam int CH  = 2;
    localparam int LEV = 2;
    localparam int DEP = 2;
    localparam int RD  = DEP + 2 * LEV + 4;
    localparam int THR = RD - 1 - 2 * LEV;
    localparam int CW  = $clog2(RD + 1);

    typedef logic [DW-1:0] word_t;

    logic              clk;
    logic              reset;
    logic              if_write_ce;
    logic [CH-1:0]     if_write;
    logic [CH*DW-1:0]  if_din;
    logic [CH-1:0]     if_full_n;
    logic              if_read_ce;
    logic [CH-1:0]     if_read;
    logic [CH-1:0]     if_empty_n;
    logic [CH*DW-1:0]  if_dout;
    logic [CH*CW-1:0]  occupancy;
    logic [CH-1:0]     overflow;
    logic              overflow_clear;

    // Each lane's model holds its FIFO contents and the words still in flight,
    // where each in-flight word carries the edge at which it lands. It also
    // keeps a history of FIFO counts, from which the delayed full_n is derived.
    word_t mq [CH][$];
    word_t fl_data [CH][$];
    int    fl_due [CH][$];
    int    hist [CH][$];
    bit    m_ov [CH];
    int    m_edges;
    bit    inj0;

    int total;
    int bad;

    relay_station_mc #(
        .DATA_WIDTH(DW),
        .CHANNELS(CH),
        .LEVEL(LEV),
        .DEPTH(DEP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .if_write_ce(if_write_ce),
        .if_write(if_write),
        .if_din(if_din),
        .if_full_n(if_full_n),
        .if_read_ce(if_read_ce),
        .if_read(if_read),
        .if_empty_n(if_empty_n),
        .if_dout(if_dout),
        .occupancy(occupancy),
        .overflow(overflow),
        .overflow_clear(overflow_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit exp_full(int k);
        if (m_edges < LEV) return 1'b0;
        return hist[k][m_edges-LEV] < THR;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < CH; k++) begin
            mq[k].delete();
            fl_data[k].delete();
            fl_due[k].delete();
            hist[k].delete();
            hist[k].push_back(0);
            m_ov[k] = 1'b0;
        end
        m_edges = 0;
    endtask

    // Advance one clock edge, updating the model from the inputs currently driven.
    task automatic step();
        bit    acc [CH];
        bit    pop [CH];
        bit    push;
        word_t d;
        if (!reset) begin
            model_reset();
            @(posedge clk);
            #1;
            return;
        end
        for (int k = 0; k < CH; k++) begin
            acc[k] = (if_write[k] && if_write_ce && exp_full(k)) || (k == 0 && inj0);
            pop[k] = if_read[k] && if_read_ce && (mq[k].size() != 0);
        end
        m_edges++;
        for (int k = 0; k < CH; k++) begin
            push = (fl_due[k].size() != 0) && (fl_due[k][0] == m_edges);
            d = '0;
            if (push) begin
                d = fl_data[k].pop_front();
                void'(fl_due[k].pop_front());
            end
            if (pop[k]) void'(mq[k].pop_front());
            if (push && mq[k].size() == RD) begin
                m_ov[k] = 1'b1;
            end else begin
                if (push) mq[k].push_back(d);
                if (overflow_clear) m_ov[k] = 1'b0;
            end
            if (acc[k]) begin
                fl_data[k].push_back(if_din[k*DW +: DW]);
                fl_due[k].push_back(m_edges + LEV);
            end
            hist[k].push_back(mq[k].size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        #1;
        total++; if (if_full_n !== 2'b00)  begin bad++; $display("[TB] FAIL reset_async full_n: got %b want 00", if_full_n); end
        total++; if (if_empty_n !== 2'b00) begin bad++; $display("[TB] FAIL reset_async empty_n: got %b want 00", if_empty_n); end
        for (int c = 0; c < 3; c++) begin
            step();
            total++; if (if_full_n !== 2'b00)  begin bad++; $display("[TB] FAIL reset full_n: got %b want 00", if_full_n); end
            total++; if (if_empty_n !== 2'b00) begin bad++; $display("[TB] FAIL reset empty_n: got %b want 00", if_empty_n); end
            total++; if (occupancy !== '0)     begin bad++; $display("[TB] FAIL reset occupancy: got %h want 0", occupancy); end
            total++; if (overflow !== 2'b00)   begin bad++; $display("[TB] FAIL reset overflow: got %b want 00", overflow); end
        end
        reset = 1'b1;
        step();
        total++; if (if_full_n !== 2'b00) begin bad++; $display("[TB] FAIL release edge1 full_n: got %b want 00", if_full_n); end
        step();
        total++; if (if_full_n !== 2'b11) begin bad++; $display("[TB] FAIL release edge2 full_n: got %b want 11", if_full_n); end
        total++; if (if_empty_n !== 2'b00 || occupancy !== '0) begin bad++; $display("[TB] FAIL release idle: empty_n %b occ %h want 00/0", if_empty_n, occupancy); end
    endtask

    task automatic test_single_write();
        if_din = '0;
        if_din[7:0] = 8'hA5;
        if_write = 2'b01;
        step();
        if_write = 2'b00;
        step();
        total++; if (if_empty_n[0] !== 1'b0) begin bad++; $display("[TB] FAIL single early empty_n: got %b want 0", if_empty_n[0]); end
        step();
        total++; if (if_empty_n !== 2'b01)         begin bad++; $display("[TB] FAIL single empty_n: got %b want 01", if_empty_n); end
        total++; if (if_dout[DW-1:0] !== 32'hA5)   begin bad++; $display("[TB] FAIL single dout: got %h want a5", if_dout[DW-1:0]); end
        total++; if (occupancy !== {CW'(0), CW'(1)}) begin bad++; $display("[TB] FAIL single occupancy: got %h want 01", occupancy); end
        if_read = 2'b01;
        step();
        if_read = 2'b00;
        total++; if (occupancy !== '0 || if_empty_n !== 2'b00) begin bad++; $display("[TB] FAIL single drain: occ %h empty_n %b", occupancy, if_empty_n); end
    endtask

    task automatic test_backpressure();
        int nxt = 0;
        int got = 0;
        int peak = 0;
        bit take;
        for (int c = 0; c < 70; c++) begin
            if_read  = (c >= 30) ? 2'b10 : 2'b00;
            if_write = (nxt < 20) ? 2'b10 : 2'b00;
            if_din[DW +: DW] = 32'(nxt);
            if (c >= 30 && mq[1].size() != 0) begin
                total++; if (if_dout[DW +: DW] !== 32'(got)) begin bad++; $display("[TB] FAIL bp order: got %0d want %0d", if_dout[DW +: DW], got); end
                got++;
            end
            take = if_write[1] && exp_full(1);
            step();
            if (take) nxt++;
            if (int'(occupancy[CW +: CW]) > peak) peak = int'(occupancy[CW +: CW]);
            total++; if (if_full_n[1] !== exp_full(1)) begin bad++; $display("[TB] FAIL bp full_n c=%0d: got %b want %b", c, if_full_n[1], exp_full(1)); end
            total++; if (occupancy[CW +: CW] !== CW'(mq[1].size())) begin bad++; $display("[TB] FAIL bp occupancy c=%0d: got %0d want %0d", c, occupancy[CW +: CW], mq[1].size()); end
            total++; if (overflow[1] !== 1'b0) begin bad++; $display("[TB] FAIL bp overflow: got %b want 0", overflow[1]); end
        end
        if_read = 2'b00;
        if_write = 2'b00;
        total++; if (peak != 9) begin bad++; $display("[TB] FAIL bp peak: got %0d want 9", peak); end
        total++; if (got != 20) begin bad++; $display("[TB] FAIL bp drained: got %0d want 20", got); end
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        if_read = 2'b11;
        for (int c = 0; c < 106; c++) begin
            if_write = (sent < 100) ? 2'b11 : 2'b00;
            if_din = {$urandom(), $urandom()};
            if (sent < 100) begin
                total++; if (if_full_n !== 2'b11) begin bad++; $display("[TB] FAIL b2b stall c=%0d: full_n %b want 11", c, if_full_n); end
            end
            for (int k = 0; k < CH; k++) begin
                if (mq[k].size() != 0) begin
                    total++; if (if_dout[k*DW +: DW] !== mq[k][0]) begin bad++; $display("[TB] FAIL b2b data lane%0d: got %h want %h", k, if_dout[k*DW +: DW], mq[k][0]); end
                end
            end
            step();
            if (sent < 100) sent++;
            if (c >= 2 && c <= 101) begin
                total++; if (if_empty_n !== 2'b11 || occupancy !== {CW'(1), CW'(1)}) begin bad++; $display("[TB] FAIL b2b bubble c=%0d: empty_n %b occ %h", c, if_empty_n, occupancy); end
            end
        end
        if_read = 2'b00;
        if_write = 2'b00;
        total++; if (occupancy !== '0) begin bad++; $display("[TB] FAIL b2b final occupancy: got %h want 0", occupancy); end
    endtask

    task automatic test_overflow();
        if_read = 2'b00;
        if_write = 2'b00;
        force dut.g_pipe.g_lane[0].wr = 1'b1;
        inj0 = 1'b1;
        for (int c = 0; c < 14; c++) begin
            if_din[DW-1:0] = 32'h100 + 32'(c);
            step();
        end
        release dut.g_pipe.g_lane[0].wr;
        inj0 = 1'b0;
        for (int c = 0; c < 3; c++) step();
        total++; if (overflow !== 2'b01) begin bad++; $display("[TB] FAIL ovf set: got %b want 01", overflow); end
        total++; if (occupancy !== {CW'(0), CW'(10)}) begin bad++; $display("[TB] FAIL ovf occupancy: got %h want 0a", occupancy); end
        total++; if (if_dout[DW-1:0] !== 32'h100) begin bad++; $display("[TB] FAIL ovf head: got %h want 100", if_dout[DW-1:0]); end

        overflow_clear = 1'b1;
        step();
        overflow_clear = 1'b0;
        total++; if (overflow !== 2'b00) begin bad++; $display("[TB] FAIL ovf clear: got %b want 00", overflow); end

        force dut.g_pipe.g_lane[0].wr = 1'b1;
        inj0 = 1'b1;
        if_din[DW-1:0] = 32'h200;
        step();
        release dut.g_pipe.g_lane[0].wr;
        inj0 = 1'b0;
        step();
        if_read = 2'b01;
        step();
        if_read = 2'b00;
        total++; if (overflow !== 2'b00) begin bad++; $display("[TB] FAIL ovf push+pop: got %b want 00", overflow); end
        total++; if (occupancy[CW-1:0] !== CW'(10)) begin bad++; $display("[TB] FAIL ovf push+pop occ: got %0d want 10", occupancy[CW-1:0]); end
        total++; if (if_dout[DW-1:0] !== 32'h101) begin bad++; $display("[TB] FAIL ovf push+pop head: got %h want 101", if_dout[DW-1:0]); end

        force dut.g_pipe.g_lane[0].wr = 1'b1;
        inj0 = 1'b1;
        if_din[DW-1:0] = 32'h300;
        step();
        release dut.g_pipe.g_lane[0].wr;
        inj0 = 1'b0;
        step();
        overflow_clear = 1'b1;
        step();
        overflow_clear = 1'b0;
        total++; if (overflow !== 2'b01) begin bad++; $display("[TB] FAIL ovf set beats clear: got %b want 01", overflow); end

        overflow_clear = 1'b1;
        step();
        overflow_clear = 1'b0;
        if_read = 2'b01;
        for (int c = 0; c < 12; c++) begin
            if (mq[0].size() != 0) begin
                total++; if (if_dout[DW-1:0] !== mq[0][0]) begin bad++; $display("[TB] FAIL ovf drain data: got %h want %h", if_dout[DW-1:0], mq[0][0]); end
            end
            step();
        end
        if_read = 2'b00;
        total++; if (occupancy !== '0 || overflow !== 2'b00) begin bad++; $display("[TB] FAIL ovf drained: occ %h ovf %b", occupancy, overflow); end
        step();
        step();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            if_write_ce    = ($urandom_range(0, 7) != 0);
            if_read_ce     = ($urandom_range(0, 7) != 0);
            if_write       = CH'($urandom());
            if_read        = CH'($urandom());
            if_din         = {$urandom(), $urandom()};
            overflow_clear = ($urandom_range(0, 31) == 0);
            step();
            for (int k = 0; k < CH; k++) begin
                total++; if (if_full_n[k] !== exp_full(k)) begin bad++; $display("[TB] FAIL rnd full_n lane%0d c=%0d: got %b want %b", k, c, if_full_n[k], exp_full(k)); end
                total++; if (if_empty_n[k] !== (mq[k].size() != 0)) begin bad++; $display("[TB] FAIL rnd empty_n lane%0d c=%0d: got %b want %b", k, c, if_empty_n[k], mq[k].size() != 0); end
                total++; if (occupancy[k*CW +: CW] !== CW'(mq[k].size())) begin bad++; $display("[TB] FAIL rnd occupancy lane%0d c=%0d: got %0d want %0d", k, c, occupancy[k*CW +: CW], mq[k].size()); end
                total++; if (overflow[k] !== m_ov[k]) begin bad++; $display("[TB] FAIL rnd overflow lane%0d: got %b want %b", k, overflow[k], m_ov[k]); end
                if (mq[k].size() != 0) begin
                    total++; if (if_dout[k*DW +: DW] !== mq[k][0]) begin bad++; $display("[TB] FAIL rnd dout lane%0d c=%0d: got %h want %h", k, c, if_dout[k*DW +: DW], mq[k][0]); end
                end
            end
        end
        if_write_ce = 1'b1;
        if_read_ce = 1'b1;
        if_write = 2'b00;
        overflow_clear = 1'b0;
        if_read = 2'b11;
        for (int c = 0; c < 20; c++) step();
        if_read = 2'b00;
        total++; if (occupancy !== '0) begin bad++; $display("[TB] FAIL rnd drain: got %h want 0", occupancy); end
    endtask

    task automatic test_reset_midstream();
        bit reached = 1'b0;
        if_write = 2'b01;
        if_read = 2'b00;
        for (int c = 0; c < 40 && !reached; c++) begin
            if_din[DW-1:0] = 32'h500 + 32'(c);
            step();
            if (mq[0].size() == 6) reached = 1'b1;
        end
        total++; if (!reached) begin bad++; $display("[TB] FAIL mid fill timeout: occupancy %0d want 6", occupancy[CW-1:0]); end
        total++; if (occupancy[CW-1:0] !== CW'(6)) begin bad++; $display("[TB] FAIL mid pre-reset occ: got %0d want 6", occupancy[CW-1:0]); end
        reset = 1'b0;
        #1;
        total++; if (if_empty_n !== 2'b00) begin bad++; $display("[TB] FAIL mid async empty_n: got %b want 00", if_empty_n); end
        total++; if (occupancy !== '0)     begin bad++; $display("[TB] FAIL mid async occupancy: got %h want 0", occupancy); end
        total++; if (if_full_n !== 2'b00)  begin bad++; $display("[TB] FAIL mid async full_n: got %b want 00", if_full_n); end
        model_reset();
        if_write = 2'b00;
        step();
        step();
        reset = 1'b1;
        step();
        step();
        total++; if (if_full_n !== 2'b11 || if_empty_n !== 2'b00) begin bad++; $display("[TB] FAIL mid post-release: full_n %b empty_n %b", if_full_n, if_empty_n); end
        for (int i = 0; i < 3; i++) begin
            if_din[DW-1:0] = 32'hC0 + 32'(i);
            if_write = 2'b01;
            step();
        end
        if_write = 2'b00;
        step();
        step();
        total++; if (occupancy[CW-1:0] !== CW'(3)) begin bad++; $display("[TB] FAIL mid new occ: got %0d want 3", occupancy[CW-1:0]); end
        if_read = 2'b01;
        for (int i = 0; i < 3; i++) begin
            total++; if (if_dout[DW-1:0] !== 32'hC0 + 32'(i)) begin bad++; $display("[TB] FAIL mid new data %0d: got %h want %h", i, if_dout[DW-1:0], 32'hC0 + 32'(i)); end
            step();
        end
        if_read = 2'b00;
        total++; if (if_empty_n !== 2'b00) begin bad++; $display("[TB] FAIL mid stale data: empty_n %b want 00", if_empty_n); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        inj0 = 1'b0;
        reset = 1'b1;
        if_write_ce = 1'b1;
        if_read_ce = 1'b1;
        if_write = '0;
        if_read = '0;
        if_din = '0;
        overflow_clear = 1'b0;
        #2;
        test_reset();
        test_single_write();
        test_backpressure();
        test_back_to_back();
        test_overflow();
        test_random();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: run did not complete, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
